bus_rr_arbiter: RTL and testbench
=================================

BUS_RR_ARBITER -- requirements
Module: bus_rr_arbiter

Interface
REQ-001 Parameter bits, default 1: number of independent buses.
REQ-002 Parameter drvrs, default 4: drivers per bus, range 2..255.
REQ-003 Parameter pckg_sz, default 16: packet width in bits; upper 8 bits are the destination ID, minimum 9.
REQ-004 Parameter broadcast, default 8'hFF: destination ID meaning "all drivers".
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 reset  input  1  asynchronous, active-low reset.
REQ-007 mode  input  1  arbitration mode: 0 = round-robin, 1 = fixed priority (lowest index wins).
REQ-008 pndng  input  [bits][drvrs]  driver FIFO non-empty; head data valid on D_pop while high.
REQ-009 D_pop  input  [bits][drvrs][pckg_sz]  head-of-FIFO packet per driver.
REQ-010 pop  output  [bits][drvrs]  one-cycle dequeue strobe to a driver FIFO.
REQ-011 push  output  [bits][drvrs]  one-cycle enqueue strobe to destination driver(s).
REQ-012 D_push  output  [bits][pckg_sz]  packet on bus, shared by all drivers of that bus.
REQ-013 drop_cnt  output  [bits][16]  per-bus count of dropped packets, saturating at 16'hFFFF.

Function
REQ-014 Each bus SHALL have an independent FSM: IDLE, POP, PUSH; no bus SHALL stall another.
REQ-015 IDLE: when any pndng bit of the bus is high at a rising edge, select grant index gnt and go to POP; otherwise stay in IDLE.
REQ-016 POP: pop[gnt] high for exactly one cycle; at the closing edge latch D_pop[gnt] and go to PUSH.
REQ-017 PUSH: D_push holds the latched packet; push mask high for exactly one cycle; then go to IDLE.
REQ-018 Latency: push SHALL assert two cycles after the edge at which IDLE sampled pndng; throughput is one packet per 3 cycles per bus.
REQ-019 Round-robin: search starts at (last_gnt+1) mod drvrs and wraps; after a grant, last_gnt = gnt; last_gnt reset value = drvrs-1, so driver 0 wins first.
REQ-020 Fixed priority: lowest pending index wins; last_gnt is still updated.
REQ-021 mode SHALL be sampled only in IDLE; a change during POP/PUSH takes effect at the next arbitration.
REQ-022 Destination ID < drvrs: push mask = one-hot of the ID (loopback to source allowed).
REQ-023 Destination ID == broadcast: push mask = all drivers except source gnt.
REQ-024 Any other ID: push mask all zero, packet dropped, drop_cnt increments in PUSH; no increment at 16'hFFFF.
REQ-025 pop and push SHALL never be high in the same cycle on one bus; at most one pop bit per bus per cycle.
REQ-026 pndng deasserting during POP SHALL NOT abort the transfer; packet as latched is delivered.
REQ-027 D_push SHALL hold its last value outside PUSH.

Reset
REQ-028 While reset is low: all FSMs IDLE, pop = 0, push = 0, D_push = 0, drop_cnt = 0, last_gnt = drvrs-1, asynchronously.
REQ-029 Reset asserted mid-transfer SHALL discard the packet in flight; no push is issued for it after release.
REQ-030 First arbitration SHALL occur at the first rising edge after reset deasserts.

Structure
REQ-031 A shared package SHALL hold the FSM state enum, the ID field width (8), and a function computing the push mask from ID, source, drvrs and broadcast.
REQ-032 One sub-module, bus_rr_lane, SHALL implement a single bus FSM, arbiter and drop counter; the top instantiates bits copies in a generate loop.

Verification
REQ-033 bits=1, drvrs=4, pckg_sz=16: driver 1 pending with 16'h0234 -> pop[1] one cycle, then push=4'b0100 with D_push=16'h0234 two cycles after sampling.
REQ-034 mode=0, all four drivers pending continuously -> grant order 0,1,2,3,0, one push every 3 cycles.
REQ-035 mode=1, drivers 2 and 3 pending continuously -> driver 2 always granted, driver 3 starved.
REQ-036 Driver 0 sends 16'hFF55 -> push=4'b1110, D_push=16'hFF55.
REQ-037 Driver 3 sends 16'h0711 -> push=4'b0000, drop_cnt=1; preload drop_cnt to FFFF, then send again -> stays 16'hFFFF.
REQ-038 bits=2: reset pulled low during POP on bus 0 while bus 1 idle -> all outputs 0 immediately; after release, no push for the lost packet; bus 0 re-arbitrates from driver 0.

Source files
------------

// File: rtl/bus_rr_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter_pkg
//   Shared definitions for the multi-bus packet arbiter:
//     - lane_state_e   : per-bus transfer FSM states (IDLE -> POP -> PUSH)
//     - ID_W           : width of the destination ID field (top bits of a packet)
//     - calc_push_mask : destination decode (unicast / broadcast / drop)
// -----------------------------------------------------------------------------
package bus_rr_arbiter_pkg;

  localparam int ID_W     = 8;
  localparam int MAX_DRV  = 256;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_POP  = 2'd1,
    ST_PUSH = 2'd2
  } lane_state_e;

  // Destination decode. Returns a mask as wide as the largest legal bus;
  // callers truncate it to their own driver count.
  //   id <  n_drv   : one-hot of id (the source may address itself)
  //   id == bcast   : every driver except the source
  //   anything else : all zero, meaning the packet is dropped
  function automatic logic [MAX_DRV-1:0] calc_push_mask(
    input logic [ID_W-1:0] id,
    input logic [ID_W-1:0] src,
    input int              n_drv,
    input logic [ID_W-1:0] bcast
  );
    logic [MAX_DRV-1:0] mask;
    mask = '0;
    if (int'(id) < n_drv) begin
      mask[id] = 1'b1;
    end else if (id == bcast) begin
      for (int i = 0; i < MAX_DRV; i++) begin
        mask[i] = (i < n_drv) && (i != int'(src));
      end
    end
    return mask;
  endfunction

endpackage

// File: rtl/bus_rr_lane.sv
// -----------------------------------------------------------------------------
// bus_rr_lane
//   One bus: arbiter, three-state transfer FSM and saturating drop counter.
//
// Handshake: i_pndng[n] high means driver n's FIFO head is valid on
// i_d_pop[n]. The lane answers with a single-cycle o_pop[n] strobe (dequeue)
// and, one cycle later, a single-cycle o_push mask with the packet on
// o_d_push. pop and push never overlap; a transfer, once granted, completes
// even if i_pndng drops, unless reset intervenes.
//
// Ports
//   i_clk, i_rst_n   clock, asynchronous active-low reset
//   i_mode           0 = round-robin, 1 = fixed priority (lowest index)
//   i_pndng          per-driver FIFO non-empty
//   i_d_pop          per-driver FIFO head packet
//   o_pop            dequeue strobe (one-hot, POP state only)
//   o_push           enqueue mask (PUSH state only)
//   o_d_push         last latched packet, held outside PUSH
//   o_drop_cnt       dropped-packet count, saturating
//   o_state          current FSM state, for observation
// -----------------------------------------------------------------------------
module bus_rr_lane
  import bus_rr_arbiter_pkg::*;
#(
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                            i_clk,
  input  logic                            i_rst_n,
  input  logic                            i_mode,
  input  logic [drvrs-1:0]                i_pndng,
  input  logic [drvrs-1:0][pckg_sz-1:0]   i_d_pop,
  output logic [drvrs-1:0]                o_pop,
  output logic [drvrs-1:0]                o_push,
  output logic [pckg_sz-1:0]              o_d_push,
  output logic [15:0]                     o_drop_cnt,
  output logic [1:0]                      o_state
);

  localparam int GW = (drvrs > 2) ? $clog2(drvrs) : 1;

  lane_state_e          r_state;
  logic [GW-1:0]        r_gnt;
  logic [GW-1:0]        r_last_gnt;
  logic [pckg_sz-1:0]   r_data;
  logic [drvrs-1:0]     r_mask;
  logic [15:0]          r_drop_cnt;

  logic                 w_any;
  logic                 w_found;
  logic [GW-1:0]        w_sel;
  int                   w_idx;
  logic [pckg_sz-1:0]   w_head;
  logic [ID_W-1:0]      w_id;
  logic [drvrs-1:0]     w_mask_next;

  assign w_any = |i_pndng;

  // Grant selection. Round-robin scans from the driver after the previous
  // grant and wraps; fixed priority takes the lowest pending index. Both
  // modes feed the same last-grant register so switching modes is seamless.
  always_comb begin
    w_sel   = r_last_gnt;
    w_found = 1'b0;
    w_idx   = 0;
    if (i_mode) begin
      for (int i = 0; i < drvrs; i++) begin
        if (!w_found && i_pndng[GW'(i)]) begin
          w_sel   = GW'(i);
          w_found = 1'b1;
        end
      end
    end else begin
      for (int k = 1; k <= drvrs; k++) begin
        w_idx = int'(r_last_gnt) + k;
        if (w_idx >= drvrs) begin
          w_idx = w_idx - drvrs;
        end
        if (!w_found && i_pndng[GW'(w_idx)]) begin
          w_sel   = GW'(w_idx);
          w_found = 1'b1;
        end
      end
    end
  end

  // Head of the granted FIFO and its destination decode, captured at the
  // end of POP.
  assign w_head      = i_d_pop[r_gnt];
  assign w_id        = w_head[pckg_sz-1 -: ID_W];
  assign w_mask_next = drvrs'(calc_push_mask(w_id, ID_W'(r_gnt), drvrs, broadcast));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state    <= ST_IDLE;
      r_gnt      <= '0;
      r_last_gnt <= GW'(drvrs - 1);
      r_data     <= '0;
      r_mask     <= '0;
      r_drop_cnt <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_gnt      <= w_sel;
            r_last_gnt <= w_sel;
            r_state    <= ST_POP;
          end
        end
        ST_POP: begin
          // Latched unconditionally: a driver dropping pndng here does not
          // cancel the transfer already granted.
          r_data  <= w_head;
          r_mask  <= w_mask_next;
          r_state <= ST_PUSH;
        end
        ST_PUSH: begin
          // An all-zero mask can only come from an unknown destination,
          // since unicast and broadcast (drvrs >= 2) always set a bit.
          if ((r_mask == '0) && (r_drop_cnt != 16'hFFFF)) begin
            r_drop_cnt <= r_drop_cnt + 16'd1;
          end
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    o_pop  = '0;
    o_push = '0;
    if (r_state == ST_POP) begin
      for (int i = 0; i < drvrs; i++) begin
        o_pop[i] = (r_gnt == GW'(i));
      end
    end
    if (r_state == ST_PUSH) begin
      o_push = r_mask;
    end
  end

  assign o_d_push   = r_data;
  assign o_drop_cnt = r_drop_cnt;
  assign o_state    = r_state;

endmodule

// File: rtl/bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// bus_rr_arbiter
//   'bits' independent packet buses, each moving packets from the head of one
//   driver FIFO to the destination driver(s) of the same bus. Each bus is a
//   bus_rr_lane; buses share nothing but the clock, reset and mode input.
//
// Ports
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   mode       0 = round-robin, 1 = fixed priority
//   pndng      [bus][drv]            FIFO non-empty
//   D_pop      [bus][drv][pckg_sz]   FIFO head packets
//   pop        [bus][drv]            dequeue strobes
//   push       [bus][drv]            enqueue strobes
//   D_push     [bus][pckg_sz]        packet on each bus
//   drop_cnt   [bus][16]             dropped-packet counters
//   dbg_state  [bus][2]              per-bus FSM state (observation only)
// -----------------------------------------------------------------------------
module bus_rr_arbiter
  import bus_rr_arbiter_pkg::*;
#(
  parameter int              bits      = 1,
  parameter int              drvrs     = 4,
  parameter int              pckg_sz   = 16,
  parameter logic [ID_W-1:0] broadcast = 8'hFF
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    mode,
  input  logic [bits-1:0][drvrs-1:0]              pndng,
  input  logic [bits-1:0][drvrs-1:0][pckg_sz-1:0] D_pop,
  output logic [bits-1:0][drvrs-1:0]              pop,
  output logic [bits-1:0][drvrs-1:0]              push,
  output logic [bits-1:0][pckg_sz-1:0]            D_push,
  output logic [bits-1:0][15:0]                   drop_cnt,
  output logic [bits-1:0][1:0]                    dbg_state
);

  for (genvar g = 0; g < bits; g++) begin : g_lane
    bus_rr_lane #(
      .drvrs     (drvrs),
      .pckg_sz   (pckg_sz),
      .broadcast (broadcast)
    ) u_lane (
      .i_clk      (clk),
      .i_rst_n    (reset),
      .i_mode     (mode),
      .i_pndng    (pndng[g]),
      .i_d_pop    (D_pop[g]),
      .o_pop      (pop[g]),
      .o_push     (push[g]),
      .o_d_push   (D_push[g]),
      .o_drop_cnt (drop_cnt[g]),
      .o_state    (dbg_state[g])
    );
  end

endmodule

// File: tb/tb_bus_rr_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bus_rr_arbiter
//   Directed bench for a two-bus, four-driver, 16-bit arbiter. Inputs change
//   and outputs are sampled 1 time unit after each rising edge.
// -----------------------------------------------------------------------------
module tb_bus_rr_arbiter;

  localparam int BITS = 2;
  localparam int DRV  = 4;
  localparam int PW   = 16;

  logic                              clk;
  logic                              reset;
  logic                              mode;
  logic [BITS-1:0][DRV-1:0]          pndng;
  logic [BITS-1:0][DRV-1:0][PW-1:0]  d_pop;
  logic [BITS-1:0][DRV-1:0]          pop;
  logic [BITS-1:0][DRV-1:0]          push;
  logic [BITS-1:0][PW-1:0]           d_push;
  logic [BITS-1:0][15:0]             drop_cnt;
  logic [BITS-1:0][1:0]              dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  // {expected pop, expected push} for the round-robin burst
  logic [7:0] exp_q[$];

  bus_rr_arbiter #(
    .bits      (BITS),
    .drvrs     (DRV),
    .pckg_sz   (PW),
    .broadcast (8'hFF)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .pndng     (pndng),
    .D_pop     (d_pop),
    .pop       (pop),
    .push      (push),
    .D_push    (d_push),
    .drop_cnt  (drop_cnt),
    .dbg_state (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // One drop transfer of 16'h0711 from driver 3 on bus 0, checking the
  // counter after the PUSH cycle closes.
  task automatic send_drop(input logic [15:0] exp_cnt, input string tag);
    pndng[0] = 4'b1000;
    d_pop[0][3] = 16'h0711;
    tick();
    check({tag, "_pop"}, 32'(pop[0]), 32'h8);
    pndng[0] = 4'b0000;
    tick();
    check({tag, "_push"}, 32'(push[0]), 32'h0);
    tick();
    check({tag, "_cnt"}, 32'(drop_cnt[0]), 32'(exp_cnt));
  endtask

  logic [7:0] e;

  initial begin
    reset = 1'b0;
    mode  = 1'b0;
    pndng = '0;
    d_pop = '0;

    // ---------------- reset state ----------------
    #2;
    check("rst_pop",  32'(pop),      32'h0);
    check("rst_push", 32'(push),     32'h0);
    check("rst_dpush", 32'(d_push),  32'h0);
    check("rst_drop", 32'(drop_cnt), 32'h0);
    tick();
    tick();

    // ---------------- basic unicast, both buses ----------------
    reset = 1'b1;
    pndng[0] = 4'b0010;
    d_pop[0][1] = 16'h0234;
    pndng[1] = 4'b0100;
    d_pop[1][2] = 16'h03C3;
    tick();
    check("uni_pop0", 32'(pop[0]), 32'h2);
    check("uni_push0_in_pop", 32'(push[0]), 32'h0);
    check("uni_pop1", 32'(pop[1]), 32'h4);
    pndng = '0;  // deasserting during POP must not cancel the transfer
    tick();
    check("uni_pop0_clear", 32'(pop[0]), 32'h0);
    check("uni_push0", 32'(push[0]), 32'h4);
    check("uni_dpush0", 32'(d_push[0]), 32'h0234);
    check("uni_push1", 32'(push[1]), 32'h8);
    check("uni_dpush1", 32'(d_push[1]), 32'h03C3);
    tick();
    check("uni_push0_one_cycle", 32'(push[0]), 32'h0);
    check("uni_dpush0_hold", 32'(d_push[0]), 32'h0234);

    // ---------------- broadcast from driver 0 ----------------
    pndng[0] = 4'b0001;
    d_pop[0][0] = 16'hFF55;
    tick();
    check("bc_pop", 32'(pop[0]), 32'h1);
    pndng[0] = 4'b0000;
    tick();
    check("bc_push", 32'(push[0]), 32'hE);
    check("bc_dpush", 32'(d_push[0]), 32'hFF55);
    tick();

    // ---------------- drops and saturation ----------------
    send_drop(16'h0001, "drop1");
    dut.g_lane[0].u_lane.r_drop_cnt = 16'hFFFE;
    send_drop(16'hFFFF, "drop_to_max");
    send_drop(16'hFFFF, "drop_sat");
    check("drop_bus1_indep", 32'(drop_cnt[1]), 32'h0);

    // ---------------- round-robin, all pending ----------------
    // last grant is 3, so the order is 0,1,2,3,0
    d_pop[0][0] = 16'h01A0;
    d_pop[0][1] = 16'h02A1;
    d_pop[0][2] = 16'h03A2;
    d_pop[0][3] = 16'h00A3;
    exp_q.push_back({4'b0001, 4'b0010});
    exp_q.push_back({4'b0010, 4'b0100});
    exp_q.push_back({4'b0100, 4'b1000});
    exp_q.push_back({4'b1000, 4'b0001});
    exp_q.push_back({4'b0001, 4'b0010});
    mode = 1'b0;
    pndng[0] = 4'b1111;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      tick();
      check("rr_pop", 32'(pop[0]), 32'(e[7:4]));
      check("rr_no_push_in_pop", 32'(push[0]), 32'h0);
      tick();
      check("rr_push", 32'(push[0]), 32'(e[3:0]));
      check("rr_no_pop_in_push", 32'(pop[0]), 32'h0);
      tick();
      check("rr_idle_push", 32'(push[0]), 32'h0);
    end

    // ---------------- fixed priority, 2 and 3 pending ----------------
    mode = 1'b1;
    pndng[0] = 4'b1100;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("fp_pop", 32'(pop[0]), 32'h4);
      tick();
      check("fp_push", 32'(push[0]), 32'h8);
      check("fp_dpush", 32'(d_push[0]), 32'h03A2);
      tick();
    end

    // back to round-robin: last grant is 2, so driver 3 wins
    mode = 1'b0;
    tick();
    check("mode_rr_after_fp", 32'(pop[0]), 32'h8);
    mode = 1'b1;  // change mid-transfer; takes effect at next arbitration
    tick();
    check("mode_mid_push", 32'(push[0]), 32'h1);
    tick();
    tick();
    check("mode_fp_next", 32'(pop[0]), 32'h4);
    pndng[0] = 4'b0000;
    tick();
    tick();
    mode = 1'b0;

    // ---------------- reset mid-transfer ----------------
    pndng[0] = 4'b0010;
    d_pop[0][1] = 16'h0234;
    tick();
    check("mid_pop", 32'(pop[0]), 32'h2);
    #2;
    reset = 1'b0;
    #1;
    check("mid_rst_pop",   32'(pop),      32'h0);
    check("mid_rst_push",  32'(push),     32'h0);
    check("mid_rst_dpush", 32'(d_push),   32'h0);
    check("mid_rst_drop",  32'(drop_cnt), 32'h0);
    pndng = '0;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check("mid_no_push", 32'(push), 32'h0);
    end
    pndng[0] = 4'b1111;
    tick();
    check("mid_rearb_drv0", 32'(pop[0]), 32'h1);
    pndng = '0;
    tick();
    tick();

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
